// File: rtl/ibuf_seq_ctrl_if.sv
// Column-word stream between tile fetch logic and the input-buffer sequencer.
// Ports: valid/word from the fetcher (master), ready from the sequencer (slave).
interface ibuf_seq_ctrl_if #(
  parameter int DW = 32
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] word;

  modport master (
    output valid,
    output word,
    input  ready
  );

  modport slave (
    input  valid,
    input  word,
    output ready
  );
endinterface

// File: rtl/ibuf_seq_ctrl.sv
// Input-buffer sequencer: loads NCOL column words, drives START_CALC, drains.
// Ports: i_clk, i_rst (sync, high), i_start, i_odst_tag, i_abort, i_in (word stream),
//        o_load_en/o_icol/o_iword (column write), o_start_calc, o_odst, o_busy, o_done.
module ibuf_seq_ctrl #(
  parameter int NCOL      = 4,
  parameter int NROW      = 4,
  parameter int DRAIN_CYC = 7,
  parameter int DW        = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [3:0]              i_odst_tag,
  input  logic                    i_abort,
  ibuf_seq_ctrl_if.slave          i_in,
  output logic                    o_load_en,
  output logic [$clog2(NCOL)-1:0] o_icol,
  output logic [DW-1:0]           o_iword,
  output logic                    o_start_calc,
  output logic [3:0]              o_odst,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int CW  = $clog2(NCOL);
  localparam int RW  = (NROW > 1) ? $clog2(NROW) : 1;
  localparam int DCL = $clog2(DRAIN_CYC + 1);
  localparam int DCW = (DCL > 0) ? DCL : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic [DCW-1:0] r_drn;
  logic [3:0]     r_tag;

  logic           r_load_en;
  logic [CW-1:0]  r_icol;
  logic [DW-1:0]  r_iword;
  logic           r_sc;
  logic [3:0]     r_odst;
  logic           r_done;

  logic w_hs;
  logic w_wr;
  logic w_last_col;
  logic w_last_row;
  logic w_last_drn;
  logic w_sc_nxt;
  logic w_done_nxt;
  logic w_accept;

  assign i_in.ready = (r_state == S_LOAD);
  assign w_hs       = (r_state == S_LOAD) && i_in.valid;
  // A handshake in the abort cycle still happens but its write is dropped.
  assign w_wr       = w_hs && !i_abort;
  assign w_accept   = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_last_col = (r_col == CW'(NCOL - 1));
  assign w_last_row = (r_row == RW'(NROW - 1));
  // Drain stays DRAIN_CYC+1 cycles: the first one still shows the last START_CALC.
  assign w_last_drn = (r_drn == DCW'(DRAIN_CYC));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_sc_nxt   = 1'b0;
    w_done_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) w_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (w_hs && w_last_col) w_nxt = S_CALC;
      end
      S_CALC: begin
        w_sc_nxt = 1'b1;
        if (w_last_row) w_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_last_drn) begin
          w_nxt      = S_IDLE;
          w_done_nxt = 1'b1;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
    if (i_abort) begin
      w_nxt      = S_IDLE;
      w_sc_nxt   = 1'b0;
      w_done_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_drn     <= '0;
      r_tag     <= '0;
      r_load_en <= 1'b0;
      r_icol    <= '0;
      r_iword   <= '0;
      r_sc      <= 1'b0;
      r_odst    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_load_en <= w_wr;
      r_icol    <= w_wr ? r_col : '0;
      r_iword   <= w_wr ? i_in.word : '0;
      r_sc      <= w_sc_nxt;
      r_odst    <= w_sc_nxt ? r_tag : 4'd0;
      r_done    <= w_done_nxt;

      if (w_accept) r_tag <= i_odst_tag;

      if (i_abort || r_state == S_IDLE) begin
        r_col <= '0;
      end else if (w_hs && !w_last_col) begin
        r_col <= r_col + CW'(1);
      end

      if (i_abort || r_state != S_CALC) begin
        r_row <= '0;
      end else if (!w_last_row) begin
        r_row <= r_row + RW'(1);
      end

      if (i_abort || r_state != S_DRAIN) begin
        r_drn <= '0;
      end else if (!w_last_drn) begin
        r_drn <= r_drn + DCW'(1);
      end
    end
  end

  assign o_load_en    = r_load_en;
  assign o_icol       = r_icol;
  assign o_iword      = r_iword;
  assign o_start_calc = r_sc;
  assign o_odst       = r_odst;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;

endmodule

// File: tb/tb_ibuf_seq_ctrl.sv
// Bench for ibuf_seq_ctrl: event-timeline model feeds queues, negedge monitor checks.
// Two instances: default parameters and NCOL=2/NROW=3/DRAIN_CYC=0.
module tb_ibuf_seq_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort, valid, sel;
  logic [3:0]  tag;
  logic [31:0] word;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  ibuf_seq_ctrl_if #(.DW(32)) a_if ();
  ibuf_seq_ctrl_if #(.DW(32)) b_if ();
  assign a_if.valid = valid;
  assign a_if.word  = word;
  assign b_if.valid = valid;
  assign b_if.word  = word;

  logic        a_start, b_start;
  assign a_start = start & ~sel;
  assign b_start = start & sel;

  logic        a_le, a_sc, a_busy, a_done;
  logic [1:0]  a_icol;
  logic [31:0] a_iword;
  logic [3:0]  a_odst;
  logic        b_le, b_sc, b_busy, b_done;
  logic [0:0]  b_icol;
  logic [31:0] b_iword;
  logic [3:0]  b_odst;

  ibuf_seq_ctrl #(.NCOL(4), .NROW(4), .DRAIN_CYC(7), .DW(32)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_odst_tag(tag),
    .i_abort(abort), .i_in(a_if), .o_load_en(a_le), .o_icol(a_icol),
    .o_iword(a_iword), .o_start_calc(a_sc), .o_odst(a_odst),
    .o_busy(a_busy), .o_done(a_done)
  );

  ibuf_seq_ctrl #(.NCOL(2), .NROW(3), .DRAIN_CYC(0), .DW(32)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_odst_tag(tag),
    .i_abort(abort), .i_in(b_if), .o_load_en(b_le), .o_icol(b_icol),
    .o_iword(b_iword), .o_start_calc(b_sc), .o_odst(b_odst),
    .o_busy(b_busy), .o_done(b_done)
  );

  logic        m_le, m_sc, m_busy, m_done, m_ready;
  logic [1:0]  m_icol;
  logic [31:0] m_iword;
  logic [3:0]  m_odst;
  always_comb begin
    m_le    = sel ? b_le : a_le;
    m_icol  = sel ? {1'b0, b_icol} : a_icol;
    m_iword = sel ? b_iword : a_iword;
    m_sc    = sel ? b_sc : a_sc;
    m_odst  = sel ? b_odst : a_odst;
    m_busy  = sel ? b_busy : a_busy;
    m_done  = sel ? b_done : a_done;
    m_ready = sel ? b_if.ready : a_if.ready;
  end

  typedef struct {
    int          cyc;
    int          col;
    logic [31:0] data;
  } ev_t;

  ev_t lq[$];
  ev_t cq[$];
  ev_t dq[$];

  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 0;
  bit  exp_ready, exp_busy;

  int          ncol, nrow, dcyc;
  bit          m_load;
  int          m_acc, m_done_at;
  logic [3:0]  m_tag;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic void purge(int k);
    while (lq.size() > 0 && lq[$].cyc > k) void'(lq.pop_back());
    while (cq.size() > 0 && cq[$].cyc > k) void'(cq.pop_back());
    while (dq.size() > 0 && dq[$].cyc > k) void'(dq.pop_back());
  endfunction

  // Tile timeline: last accept at t -> writes at accept+1, START_CALC at
  // t+2..t+1+nrow, DONE at t+2+nrow+dcyc; busy from load until DONE.
  task automatic drive(bit s, logic [3:0] tg, bit ab, bit r, bit v,
                       logic [31:0] w);
    int k;
    k = cyc;
    start = s; tag = tg; abort = ab; rst = r; valid = v; word = w;
    exp_ready = m_load;
    exp_busy  = m_load || (k < m_done_at);
    if (ab || r) begin
      m_load    = 0;
      m_done_at = 0;
      purge(k);
    end else if (m_load) begin
      if (v) begin
        lq.push_back('{k + 1, m_acc, w});
        m_acc++;
        if (m_acc == ncol) begin
          m_load = 0;
          for (int i = 0; i < nrow; i++)
            cq.push_back('{k + 2 + i, 0, {28'd0, m_tag}});
          m_done_at = k + 2 + nrow + dcyc;
          dq.push_back('{m_done_at, 0, 32'd0});
        end
      end
    end else if (!exp_busy && s) begin
      m_load = 1;
      m_acc  = 0;
      m_tag  = tg;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 4'd0, 0, 0, 0, 32'd0);
  endtask

  always @(negedge clk) begin
    bit e;
    if (mon_en) begin
      e = (lq.size() > 0 && lq[0].cyc == cyc);
      chk("load_en", {31'd0, m_le}, {31'd0, e});
      if (e) begin
        if (m_le) begin
          chk("icol", {30'd0, m_icol}, lq[0].col);
          chk("iword", m_iword, lq[0].data);
        end
        void'(lq.pop_front());
      end
      e = (cq.size() > 0 && cq[0].cyc == cyc);
      chk("start_calc", {31'd0, m_sc}, {31'd0, e});
      chk("odst", {28'd0, m_odst}, e ? cq[0].data : 32'd0);
      if (e) void'(cq.pop_front());
      e = (dq.size() > 0 && dq[0].cyc == cyc);
      chk("done", {31'd0, m_done}, {31'd0, e});
      if (e) void'(dq.pop_front());
      chk("in_ready", {31'd0, m_ready}, {31'd0, exp_ready});
      chk("busy", {31'd0, m_busy}, {31'd0, exp_busy});
    end
  end

  logic [31:0] t1w [4];
  bit          t2v [7];

  initial begin
    t1w[0] = 32'h11223344; t1w[1] = 32'h55667788;
    t1w[2] = 32'h99AABBCC; t1w[3] = 32'hDDEEFF00;
    t2v[0] = 1; t2v[1] = 0; t2v[2] = 0; t2v[3] = 1;
    t2v[4] = 1; t2v[5] = 0; t2v[6] = 1;
    sel = 0; ncol = 4; nrow = 4; dcyc = 7;
    m_load = 0; m_acc = 0; m_done_at = 0; m_tag = 0;
    start = 0; abort = 0; valid = 0; rst = 1; tag = 0; word = 0;
    @(posedge clk);
    #1;
    drive(0, 4'd0, 0, 1, 0, 32'd0);
    drive(0, 4'd0, 0, 1, 0, 32'd0);
    mon_en = 1;
    idle(2);

    drive(1, 4'd5, 0, 0, 0, 32'd0);
    for (int i = 0; i < 4; i++) drive(0, 4'd0, 0, 0, 1, t1w[i]);
    idle(20);

    drive(1, 4'd9, 0, 0, 0, 32'd0);
    for (int i = 0; i < 7; i++) drive(0, 4'd0, 0, 0, t2v[i], $urandom);
    idle(20);

    repeat (40) drive(1, 4'd3, 0, 0, 1, $urandom);
    idle(20);

    drive(1, 4'd7, 0, 0, 0, 32'd0);
    drive(0, 4'd0, 0, 0, 1, 32'hA0A0A0A0);
    drive(0, 4'd0, 0, 0, 1, 32'hB1B1B1B1);
    drive(0, 4'd0, 1, 0, 1, 32'hC2C2C2C2);
    idle(3);
    drive(1, 4'd6, 0, 0, 0, 32'd0);
    for (int i = 0; i < 4; i++) drive(0, 4'd0, 0, 0, 1, $urandom);
    idle(20);

    drive(1, 4'd12, 0, 0, 0, 32'd0);
    for (int i = 0; i < 4; i++) drive(0, 4'd0, 0, 0, 1, $urandom);
    idle(2);
    drive(0, 4'd0, 0, 1, 0, 32'd0);
    idle(15);

    drive(1, 4'd2, 1, 0, 0, 32'd0);
    idle(5);

    repeat (400)
      drive($urandom_range(0, 4) == 0, 4'($urandom),
            $urandom_range(0, 49) == 0, 0,
            $urandom_range(0, 2) != 0, $urandom);
    idle(30);

    sel = 1; ncol = 2; nrow = 3; dcyc = 0;
    idle(2);
    drive(1, 4'hA, 0, 0, 0, 32'd0);
    drive(0, 4'd0, 0, 0, 1, 32'hCAFEF00D);
    drive(0, 4'd0, 0, 0, 1, 32'h0BADBEEF);
    idle(10);
    repeat (300)
      drive($urandom_range(0, 3) == 0, 4'($urandom),
            $urandom_range(0, 49) == 0, 0,
            $urandom_range(0, 2) != 0, $urandom);
    idle(20);

    chk("load_q_empty", lq.size(), 0);
    chk("calc_q_empty", cq.size(), 0);
    chk("done_q_empty", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
